// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, data bits D7..D0 (MSB first), one stop bit.
// A one-byte holding register is refilled while the current frame shifts
// out, so back-to-back frames leave no idle cycles on the line.
module uart_transmitter #(
    parameter int BAUD_DIV = 1302,  // clock cycles per bit period
    parameter int CNT_W    = 12     // width of the bit-period counter
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_8_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shifter, shifter_next;
    logic [7:0]       hold_data;
    logic             hold_full;
    logic             tx_q, tx_next;
    logic             done_q;

    logic bit_end;  // last cycle of the current bit period
    logic load;     // holding register moves into the shifter on this edge
    logic accept;   // producer byte is captured on this edge

    assign bit_end = (cnt == LAST_CNT);
    // A frame may start from idle, or directly after the final stop-bit cycle.
    assign load    = hold_full && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    // Accept and load are mutually exclusive: one needs hold_full=0, the other 1.
    assign accept  = i_valid && !hold_full;

    // Holding register: capture on handshake, release when the shifter loads.
    // NOTE: every clocked block uses non-blocking (<=) so all flops update from
    // the same pre-edge values, regardless of block evaluation order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_data <= i_8_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Frame state, bit timing and the registered line/done outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= 3'd7;
            shifter <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shifter <= shifter_next;
            tx_q    <= tx_next;
            done_q  <= (state == S_STOP) && bit_end;
        end
    end

    // Next-state, counter and bit-index logic; line level from current state.
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_idx_next = bit_idx;
        shifter_next = load ? hold_data : shifter;
        tx_next      = 1'b1;

        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (load) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                tx_next = 1'b0;
                if (bit_end) begin
                    cnt_next     = '0;
                    bit_idx_next = 3'd7;
                    state_next   = S_DATA;
                end
            end
            S_DATA: begin
                tx_next = shifter[bit_idx];
                if (bit_end) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd0) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx - 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = load ? S_START : S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign o_ready = ~hold_full;
    assign o_tx    = tx_q;
    assign o_busy  = (state != S_IDLE);
    assign o_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a fast instance (BAUD_DIV=4)
// compared every cycle against a frame-timeline model, plus a default-rate
// instance looped into a behavioural serial receiver.
module tb_uart_transmitter;

    localparam int B      = 4;
    localparam int LB_DIV = 1302;
    localparam int BUDGET = 40000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] data  = '0;
    logic       valid = 1'b0;
    logic       ready, tx, busy, done;

    logic [7:0] lb_data  = '0;
    logic       lb_valid = 1'b0;
    logic       lb_ready, lb_tx, lb_busy, lb_done;

    always #5 clk = ~clk;

    uart_transmitter #(.BAUD_DIV(B), .CNT_W(4)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_8_data  (data),
        .i_valid   (valid),
        .o_ready   (ready),
        .o_tx      (tx),
        .o_busy    (busy),
        .o_done    (done)
    );

    uart_transmitter lb_dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_8_data  (lb_data),
        .i_valid   (lb_valid),
        .o_ready   (lb_ready),
        .o_tx      (lb_tx),
        .o_busy    (lb_busy),
        .o_done    (lb_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model (frame timeline) ----------------
    // Edge counter cyc; a frame loaded at edge s occupies cycles s..s+10B-1,
    // and the registered line shows cycle c's level after edge c+1.
    typedef struct {
        int         start;
        logic [7:0] b;
    } frame_t;

    frame_t     frames[$];
    int         cyc         = 0;
    bit         m_hold_full = 1'b0;
    logic [7:0] m_hold_byte = '0;
    int         busy_until  = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            frames.delete();
            m_hold_full = 1'b0;
            busy_until  = 0;
        end else begin
            cyc++;
            if (m_hold_full && cyc >= busy_until) begin
                frames.push_back('{cyc, m_hold_byte});
                busy_until  = cyc + 10 * B;
                m_hold_full = 1'b0;
            end else if (valid && !m_hold_full) begin
                m_hold_full = 1'b1;
                m_hold_byte = data;
            end
        end
    end

    function automatic logic exp_tx(input int e);
        logic r = 1'b1;
        foreach (frames[i]) begin
            int p;
            if (e - 1 >= frames[i].start && e - 1 < frames[i].start + 10 * B) begin
                p = (e - 1 - frames[i].start) / B;
                if (p == 0)      r = 1'b0;
                else if (p == 9) r = 1'b1;
                else             r = frames[i].b[8 - p];
            end
        end
        return r;
    endfunction

    function automatic logic exp_done(input int e);
        logic r = 1'b0;
        foreach (frames[i]) begin
            if (frames[i].start + 10 * B == e) r = 1'b1;
        end
        return r;
    endfunction

    // Per-cycle comparison of every output of the fast instance.
    initial forever begin
        @(negedge clk);
        check("tx",    32'(tx),    32'(exp_tx(cyc)));
        check("ready", 32'(ready), 32'(!m_hold_full));
        check("busy",  32'(busy),  32'(cyc < busy_until));
        check("done",  32'(done),  32'(exp_done(cyc)));
    end

    // ---------------- serial receivers ----------------
    logic [7:0] rx_q[$], lb_rx_q[$];
    logic [7:0] sent_q[$], lb_sent_q[$];
    int         done_cnt    = 0;
    int         lb_done_cnt = 0;

    function automatic logic line(input bit which);
        return which ? lb_tx : tx;
    endfunction

    // Called at the first negedge of a start bit; samples each bit mid-period.
    task automatic rx_frame(input bit which, input int div, output logic [7:0] b, output bit ok);
        ok = 1'b1;
        b  = '0;
        repeat (div / 2) @(negedge clk);
        if (line(which) !== 1'b0 || !rst_n) ok = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            repeat (div) @(negedge clk);
            b[i] = line(which);
            if (!rst_n) ok = 1'b0;
        end
        repeat (div) @(negedge clk);
        if (line(which) !== 1'b1 || !rst_n) ok = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                rx_frame(1'b0, B, b, ok);
                if (ok) rx_q.push_back(b);
            end
        end
    end

    initial begin
        logic [7:0] b;
        bit         ok;
        forever begin
            @(negedge clk);
            if (rst_n && lb_tx === 1'b0) begin
                rx_frame(1'b1, LB_DIV, b, ok);
                if (ok) lb_rx_q.push_back(b);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (done)    done_cnt++;
        if (lb_done) lb_done_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input bit which, input logic [7:0] b, input bit keep_valid);
        int n = 0;
        if (which) begin lb_data = b; lb_valid = 1'b1; end
        else       begin data    = b; valid    = 1'b1; end
        while (!(which ? lb_ready : ready) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < BUDGET), 32'd1);
        @(negedge clk);
        if (which) begin
            lb_sent_q.push_back(b);
            if (!keep_valid) lb_valid = 1'b0;
        end else begin
            sent_q.push_back(b);
            if (!keep_valid) valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input bit which);
        int n = 0;
        while (((which ? lb_busy : busy) || !(which ? lb_ready : ready)) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(n < BUDGET), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_stream(input bit which, input string tag);
        int n_rx   = which ? lb_rx_q.size() : rx_q.size();
        int n_sent = which ? lb_sent_q.size() : sent_q.size();
        check({tag, "_count"}, 32'(n_rx), 32'(n_sent));
        for (int i = 0; i < n_rx && i < n_sent; i++) begin
            if (which) check({tag, "_byte"}, 32'(lb_rx_q[i]), 32'(lb_sent_q[i]));
            else       check({tag, "_byte"}, 32'(rx_q[i]),    32'(sent_q[i]));
        end
        if (which) begin lb_rx_q.delete(); lb_sent_q.delete(); end
        else       begin rx_q.delete();    sent_q.delete();    end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int d0;

        repeat (3) @(negedge clk);
        check("rst_tx",    32'(tx),    32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0xA5.
        d0 = done_cnt;
        send_byte(1'b0, 8'hA5, 1'b0);
        wait_idle(1'b0);
        compare_stream(1'b0, "a5");
        check("a5_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Back-to-back 0x00 then 0xFF.
        d0 = done_cnt;
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'hFF, 1'b0);
        wait_idle(1'b0);
        compare_stream(1'b0, "b2b");
        check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

        // Backpressure: i_valid stays high across three queued bytes.
        send_byte(1'b0, 8'h11, 1'b1);
        send_byte(1'b0, 8'h22, 1'b1);
        send_byte(1'b0, 8'h33, 1'b0);
        wait_idle(1'b0);
        compare_stream(1'b0, "bp");

        // A byte offered while not ready must vanish without trace.
        send_byte(1'b0, 8'h3C, 1'b0);
        send_byte(1'b0, 8'h96, 1'b0);
        check("junk_not_ready", 32'(ready), 32'd0);
        data  = 8'h55;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        data  = '0;
        wait_idle(1'b0);
        compare_stream(1'b0, "junk");

        // Random bytes, random gaps, random ignored offers while full.
        for (int k = 0; k < 24; k++) begin
            int gap = int'($urandom_range(0, 12));
            for (int g = 0; g < gap; g++) begin
                if (!ready && $urandom_range(0, 1) == 1) begin
                    data  = 8'($urandom);
                    valid = 1'b1;
                end else begin
                    valid = 1'b0;
                end
                @(negedge clk);
            end
            valid = 1'b0;
            send_byte(1'b0, 8'($urandom), 1'b0);
        end
        wait_idle(1'b0);
        compare_stream(1'b0, "rand");

        // Reset in the middle of D3 of 0xC3 with 0x5A waiting in the holding register.
        d0 = done_cnt;
        send_byte(1'b0, 8'hC3, 1'b0);
        send_byte(1'b0, 8'h5A, 1'b0);
        repeat (21) @(negedge clk);
        check("d3_level", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_tx",    32'(tx),    32'd1);
        check("async_ready", 32'(ready), 32'd1);
        check("async_busy",  32'(busy),  32'd0);
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        sent_q.delete();
        compare_stream(1'b0, "after_reset");
        check("reset_no_done", 32'(done_cnt - d0), 32'd0);

        // Loopback at the default bit period.
        send_byte(1'b1, 8'h00, 1'b0);
        send_byte(1'b1, 8'h7E, 1'b0);
        send_byte(1'b1, 8'h81, 1'b0);
        send_byte(1'b1, 8'hFF, 1'b0);
        wait_idle(1'b1);
        compare_stream(1'b1, "loopback");
        check("loopback_done_pulses", 32'(lb_done_cnt), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises bytes onto a UART TX line for a receiver that expects MSB-first framing.
- Frame is 10 bits: start bit (0), data bits D7 down to D0, one stop bit (1).
- A one-byte holding register lets the next byte be accepted while the current frame shifts out, so consecutive frames run with no idle gap.
- Sits between the byte-producing logic and the board TX pin.

Parameters:
- BAUD_DIV, 1302, clock cycles per bit period; legal range 2 to 2^CNT_W-1.
- CNT_W, 12, width of the bit-period counter.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_8_data  input  8  byte to send; sampled only on an accepted transfer.
- i_valid  input  1  producer offers i_8_data this cycle.
- o_ready  output  1  holding register empty; the byte is accepted on the edge where i_valid && o_ready.
- o_tx  output  1  serial line, idle high; registered.
- o_busy  output  1  a frame is in progress (state != sIdle).
- o_done  output  1  one-cycle pulse in the cycle after the last stop-bit cycle of each frame.

Behaviour:
- Reset (async assert, sync release):
  - o_tx=1, o_ready=1, o_busy=0, o_done=0.
  - State=sIdle, counter=0, bit index=7, holding register empty, shifter cleared.
- Accept:
  - At an edge with i_valid=1 and o_ready=1, i_8_data is copied into the holding register and hold_full is set.
  - o_ready = ~hold_full, driven directly from the flop; there is no combinational path from i_valid to o_ready.
  - i_valid while o_ready=0 is ignored and has no side effects.
- States:
  - sIdle: o_tx=1. If hold_full, on the next edge move the holding register into the shifter, clear hold_full, go to sStart, counter=0.
  - sStart: o_tx=0 for BAUD_DIV cycles, then go to sData with bit index 7.
  - sData: o_tx = shifter[bit index] for BAUD_DIV cycles per bit. Bit index steps 7 down to 0. After bit 0 completes, go to sStop.
  - sStop: o_tx=1 for BAUD_DIV cycles. At the end of the stop bit, o_done pulses.
    - If hold_full: load the shifter, clear hold_full, go to sStart. The next start bit begins in the very next cycle, with zero idle cycles.
    - Otherwise: go to sIdle.
- Timing:
  - Counter counts 0..BAUD_DIV-1 and wraps to 0 on every bit transition.
  - Each bit is held for exactly BAUD_DIV cycles.
  - The first start-bit cycle (o_tx=0) appears 2 edges after the accept edge (hold → shifter, then o_tx registered).
  - Frame length is exactly 10*BAUD_DIV cycles.
- The holding register refills as soon as it empties: o_ready rises in the cycle after the shifter load and may accept during any later bit of the current frame.
- Simultaneous events:
  - Only one of accept or transfer-to-shifter can happen on a given edge, because accept requires hold_full=0 and transfer requires hold_full=1. No ordering rule is needed.
- The shifter is not modified mid-frame, so a new accept never corrupts the frame in flight.
- Reset mid-frame:
  - o_tx returns to 1 immediately (asynchronously).
  - The frame is abandoned and the holding byte is discarded.
  - o_done does not pulse.
- o_busy=1 in sStart, sData and sStop; 0 only in sIdle.

Test Plan:
- Reset, then send 0xA5 with BAUD_DIV=4:
  - o_tx reads 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 cycles.
  - Start bit first appears 2 edges after accept.
  - o_done pulses once, then o_busy=0 and o_tx=1.
- Back-to-back 0x00 then 0xFF:
  - Second byte is accepted during the first frame (o_ready returns 1 one cycle after the shifter load).
  - The second start bit follows the first stop bit with zero idle cycles.
  - o_done pulses twice, 10*BAUD_DIV cycles apart.
- Backpressure: hold i_valid=1 with three bytes queued behind one another:
  - o_ready=0 while the holding register is full; the third byte is accepted only after frame 1 ends.
  - No byte is dropped or duplicated; serial order is 0x11, 0x22, 0x33.
- Reset mid-frame: assert i_reset_n=0 during data bit D3 of 0xC3, with a second byte in the holding register:
  - o_tx goes 1 asynchronously, o_ready=1, o_busy=0.
  - After release, the line stays idle and nothing is transmitted.
- Loopback at default BAUD_DIV=1302: o_tx feeds the team's uart_receiver.
  - Send 0x00, 0x7E, 0x81, 0xFF back-to-back.
  - Receiver o_8_data matches each byte and o_ready asserts once per frame.
- i_valid pulsed while o_ready=0 with 0x55: the byte is ignored and the transmitted stream is unchanged.
